// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer for the MIPS front end.
// Drives the shared adder with PC/4, issues fetches, and presents words to decode.
module pc_fetch_unit #(
    parameter int unsigned WIDTH    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_instr
);

    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic             req_d;
    logic             if_valid_d;
    logic [WIDTH-1:0] if_pc_d, if_instr_d;
    logic [WIDTH-1:0] tgt_aligned;
    logic             slot_free;

    assign add_a       = pc_q;
    assign add_b       = WIDTH'(PC_STEP);
    assign imem_addr   = pc_q;
    assign tgt_aligned = redirect_target & ~WIDTH'(3);
    assign slot_free   = !if_valid || !stall;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            pc_q         <= WIDTH'(RESET_PC);
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            pend_q       <= 1'b0;
            pend_tgt_q   <= '0;
            imem_req     <= 1'b0;
            if_valid     <= 1'b0;
            if_pc        <= '0;
            if_instr     <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            pend_q       <= pend_d;
            pend_tgt_q   <= pend_tgt_d;
            imem_req     <= req_d;
            if_valid     <= if_valid_d;
            if_pc        <= if_pc_d;
            if_instr     <= if_instr_d;
        end
    end

    // Next-state, PC selection and output-slot control
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        pend_d       = pend_q;
        pend_tgt_d   = pend_tgt_q;
        if_valid_d   = if_valid;
        if_pc_d      = if_pc;
        if_instr_d   = if_instr;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_ready) begin
                    if (redirect_valid) begin
                        pc_d       = tgt_aligned;
                        pend_d     = 1'b0;
                        if_valid_d = 1'b0;
                    end else if (pend_q) begin
                        // Word belongs to the squashed path; resume at latched target
                        pc_d   = pend_tgt_q;
                        pend_d = 1'b0;
                        if (!stall) begin
                            if_valid_d = 1'b0;
                        end
                    end else if (slot_free) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_q;
                        if_instr_d = imem_rdata;
                        pc_d       = add_sum;
                    end else begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_q;
                        pc_d         = add_sum;
                        state_d      = ST_HOLD;
                    end
                end else begin
                    // Outstanding request must complete before the PC can move
                    if (redirect_valid) begin
                        pend_d     = 1'b1;
                        pend_tgt_d = tgt_aligned;
                        if_valid_d = 1'b0;
                    end else if (!stall) begin
                        if_valid_d = 1'b0;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_d       = tgt_aligned;
                    if_valid_d = 1'b0;
                    state_d    = ST_REQ;
                end else if (!stall) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = skid_pc_q;
                    if_instr_d = skid_instr_q;
                    state_d    = ST_REQ;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        req_d = (state_d == ST_REQ);
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, ready gaps, stall/skid,
// redirects, PC wrap and asynchronous reset.
module tb_pc_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0400;

    logic        clk;
    logic        rst_n;
    logic [31:0] add_a, add_b, add_sum;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic [31:0] if_pc, if_instr;

    int tests = 0;
    int fails = 0;

    pc_fetch_unit #(.WIDTH(32), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
    );

    // Shared adder and instruction memory models
    assign add_sum    = add_a + add_b;
    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n           = 1'b0;
        imem_ready      = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        @(negedge clk);
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_ifpc",  if_pc,         32'h0);
        chk("rst_instr", if_instr,      32'h0);
        chk("rst_addr",  imem_addr,     RPC);
        chk("rst_adda",  add_a,         RPC);
        chk("rst_addb",  add_b,         32'd4);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: boot then sequential fetch
        step();
        chk("t1_req",    32'(imem_req), 32'd1);
        chk("t1_addr0",  imem_addr,     32'h400);
        chk("t1_val0",   32'(if_valid), 32'd0);
        step();
        chk("t1_val1",   32'(if_valid), 32'd1);
        chk("t1_pc1",    if_pc,         32'h400);
        chk("t1_ins1",   if_instr,      32'hA5A5_0400);
        chk("t1_addr1",  imem_addr,     32'h404);

        // 2: ready low for 3 clocks at 0x404
        imem_ready = 1'b0;
        step();
        chk("t2_addr_a", imem_addr,     32'h404);
        chk("t2_val_a",  32'(if_valid), 32'd0);
        step();
        step();
        chk("t2_addr_c", imem_addr,     32'h404);
        chk("t2_req_c",  32'(imem_req), 32'd1);
        imem_ready = 1'b1;
        step();
        chk("t2_val",    32'(if_valid), 32'd1);
        chk("t2_pc",     if_pc,         32'h404);
        chk("t2_addr",   imem_addr,     32'h408);
        step();
        chk("t1_pc2",    if_pc,         32'h408);
        chk("t1_addr2",  imem_addr,     32'h40C);

        // 3: stall for 4 clocks, 0x40C goes to skid
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_val",  32'(if_valid), 32'd1);
            chk("t3_pc",   if_pc,         32'h408);
            chk("t3_ins",  if_instr,      32'hA5A5_0408);
            chk("t3_req",  32'(imem_req), 32'd0);
        end
        stall = 1'b0;
        step();
        chk("t3_skidpc", if_pc,         32'h40C);
        chk("t3_skidin", if_instr,      32'hA5A5_040C);
        chk("t3_req1",   32'(imem_req), 32'd1);
        step();
        chk("t3_next",   if_pc,         32'h410);
        chk("t3_addr",   imem_addr,     32'h414);

        // 4: redirect while ready low
        imem_ready      = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_1000;
        step();
        chk("t4_val",    32'(if_valid), 32'd0);
        chk("t4_hold_a", imem_addr,     32'h414);
        redirect_valid = 1'b0;
        step();
        chk("t4_hold_b", imem_addr,     32'h414);
        imem_ready = 1'b1;
        step();
        chk("t4_drop",   32'(if_valid), 32'd0);
        chk("t4_addr",   imem_addr,     32'h1000);
        step();
        chk("t4_val2",   32'(if_valid), 32'd1);
        chk("t4_pc",     if_pc,         32'h1000);

        // 5: unaligned redirect coincident with stall
        stall           = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_2003;
        step();
        chk("t5_val",    32'(if_valid), 32'd0);
        chk("t5_addr",   imem_addr,     32'h2000);
        redirect_valid = 1'b0;
        stall          = 1'b0;
        step();
        chk("t5_pc",     if_pc,         32'h2000);

        // 6: PC wrap, then asynchronous reset mid-REQ
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        step();
        chk("t6_addr",   imem_addr,     32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        step();
        chk("t6_pc",     if_pc,         32'hFFFF_FFFC);
        chk("t6_wrap",   imem_addr,     32'h0);
        step();
        chk("t6_pc0",    if_pc,         32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_areq",   32'(imem_req), 32'd0);
        chk("t6_aval",   32'(if_valid), 32'd0);
        chk("t6_apc",    if_pc,         32'h0);
        chk("t6_aaddr",  imem_addr,     RPC);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("t6_rreq",   32'(imem_req), 32'd1);
        chk("t6_raddr",  imem_addr,     RPC);
        step();
        chk("t6_rpc",    if_pc,         RPC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
